// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if -- bundle of hazard, redirect, mode and control signals
// exchanged between the pipeline datapath and pipeline_ctrl.
//
// Signal names follow the controller's point of view:
//   i_start, i_id_rs, i_id_rt, i_ex_rt, i_ex_memread, i_branch_taken,
//   i_jump, i_halt, i_run_mode, i_step          -> into the controller
//   o_pc_write, o_ifid_write, o_ifid_flush, o_idex_bubble,
//   o_pipe_enable, o_halted, o_state            -> out of the controller
//
// Modports:
//   slave  : the controller (pipeline_ctrl)
//   master : the datapath / stimulus side
interface pipeline_ctrl_if;
  logic       i_start;
  logic [4:0] i_id_rs;
  logic [4:0] i_id_rt;
  logic [4:0] i_ex_rt;
  logic       i_ex_memread;
  logic       i_branch_taken;
  logic       i_jump;
  logic       i_halt;
  logic       i_run_mode;
  logic       i_step;

  logic       o_pc_write;
  logic       o_ifid_write;
  logic       o_ifid_flush;
  logic       o_idex_bubble;
  logic       o_pipe_enable;
  logic       o_halted;
  logic [1:0] o_state;

  modport slave (
    input  i_start, i_id_rs, i_id_rt, i_ex_rt, i_ex_memread,
           i_branch_taken, i_jump, i_halt, i_run_mode, i_step,
    output o_pc_write, o_ifid_write, o_ifid_flush, o_idex_bubble,
           o_pipe_enable, o_halted, o_state
  );

  modport master (
    output i_start, i_id_rs, i_id_rt, i_ex_rt, i_ex_memread,
           i_branch_taken, i_jump, i_halt, i_run_mode, i_step,
    input  o_pc_write, o_ifid_write, o_ifid_flush, o_idex_bubble,
           o_pipe_enable, o_halted, o_state
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl -- stall / flush / halt controller for a 5-stage pipeline.
//
// Detects load-use hazards between the load in EX and the instruction in ID,
// flushes IF/ID on taken branches and jumps, and on HALT drains EX/MEM/WB for
// DRAIN_CYCLES advancing cycles before parking in HALTED (left only by reset).
//
// Parameters:
//   DRAIN_CYCLES : advancing cycles spent draining after HALT (1..15)
//
// Ports:
//   i_clock : single clock, rising edge
//   i_reset : synchronous active-high reset
//   bus     : pipeline_ctrl_if.slave (hazard/redirect/mode inputs, controls)
//
// Optional feature: define PIPELINE_CTRL_DEBUG_STEP_EN to enable step mode,
// where the pipeline only advances when i_run_mode=1 or i_step pulses.
// Without it i_run_mode/i_step are ignored and the pipeline always advances.
//
// All control outputs are combinational from state and current inputs;
// o_state and o_halted come straight from registers.
module pipeline_ctrl #(
  parameter int DRAIN_CYCLES = 4
) (
  input  logic           i_clock,
  input  logic           i_reset,
  pipeline_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

  state_t     state_r;
  state_t     state_nxt_s;
  logic [3:0] drain_cnt_r;
  logic [3:0] drain_cnt_nxt_s;
  logic       halted_r;

  logic       adv_s;
  logic       hazard_s;

  logic       pc_write_s;
  logic       ifid_write_s;
  logic       ifid_flush_s;
  logic       idex_bubble_s;
  logic       pipe_enable_s;

`ifdef PIPELINE_CTRL_DEBUG_STEP_EN
  assign adv_s = bus.i_run_mode | bus.i_step;
`else
  // Step controls are present on the interface but have no effect here.
  logic unused_step_s;
  assign unused_step_s = bus.i_run_mode ^ bus.i_step;
  assign adv_s         = 1'b1;
`endif

  // A load into $zero never produces a value, so it cannot cause a stall.
  assign hazard_s = bus.i_ex_memread & (bus.i_ex_rt != 5'd0) &
                    ((bus.i_ex_rt == bus.i_id_rs) | (bus.i_ex_rt == bus.i_id_rt));

  // State, drain counter and halted flag registers with synchronous reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_r     <= ST_IDLE;
      drain_cnt_r <= 4'd0;
      halted_r    <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      drain_cnt_r <= drain_cnt_nxt_s;
      halted_r    <= (state_nxt_s == ST_HALTED);
    end
  end

  // Next-state, drain counter update and control outputs.
  always_comb begin
    state_nxt_s     = state_r;
    drain_cnt_nxt_s = drain_cnt_r;
    pc_write_s      = 1'b0;
    ifid_write_s    = 1'b0;
    ifid_flush_s    = 1'b0;
    idex_bubble_s   = 1'b0;
    pipe_enable_s   = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (bus.i_start) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (!adv_s) begin
          // Frozen: every control stays at its default of 0.
          state_nxt_s = ST_RUN;
        end else if (hazard_s) begin
          // Load-use stall wins over redirect/halt; those re-evaluate next cycle.
          idex_bubble_s = 1'b1;
          pipe_enable_s = 1'b1;
        end else if (bus.i_halt) begin
          // Stop fetching, kill the instruction behind HALT, start draining.
          ifid_flush_s    = 1'b1;
          pipe_enable_s   = 1'b1;
          drain_cnt_nxt_s = DRAIN_LOAD;
          state_nxt_s     = ST_DRAIN;
        end else if (bus.i_branch_taken | bus.i_jump) begin
          pc_write_s    = 1'b1;
          ifid_write_s  = 1'b1;
          ifid_flush_s  = 1'b1;
          pipe_enable_s = 1'b1;
        end else begin
          pc_write_s    = 1'b1;
          ifid_write_s  = 1'b1;
          pipe_enable_s = 1'b1;
        end
      end

      ST_DRAIN: begin
        // Hazard/redirect/halt inputs are irrelevant while draining.
        idex_bubble_s = 1'b1;
        pipe_enable_s = adv_s;
        if (adv_s) begin
          if (drain_cnt_r == 4'd1) begin
            drain_cnt_nxt_s = 4'd0;
            state_nxt_s     = ST_HALTED;
          end else begin
            drain_cnt_nxt_s = drain_cnt_r - 4'd1;
          end
        end else begin
          drain_cnt_nxt_s = drain_cnt_r;
        end
      end

      ST_HALTED: begin
        state_nxt_s = ST_HALTED;
      end

      default: begin
        state_nxt_s     = ST_IDLE;
        drain_cnt_nxt_s = 4'd0;
      end
    endcase
  end

  // While reset is asserted every control is forced low, whatever the state.
  assign bus.o_pc_write    = pc_write_s    & ~i_reset;
  assign bus.o_ifid_write  = ifid_write_s  & ~i_reset;
  assign bus.o_ifid_flush  = ifid_flush_s  & ~i_reset;
  assign bus.o_idex_bubble = idex_bubble_s & ~i_reset;
  assign bus.o_pipe_enable = pipe_enable_s & ~i_reset;
  assign bus.o_halted      = halted_r;
  assign bus.o_state       = state_r;

endmodule
